vga_timing_gen: RTL and testbench

- Parametrised raster timing generator for the text-mode display path; replaces the separate fixed-640x480 horizontal counter, vertical counter and sync blocks with one unit.
- Generates registered sync, visibility and blanking signals, plus character-cell coordinates and a lead-adjusted fetch window for the VRAM readout and pixel generator.
- Also generates line and frame strobes and a blink phase for attribute blinking.
- Sits directly after the global clock buffer and feeds readout, pixgen and vga_output.

---
 rtl/vga_pkg.sv | 47 ++++
 rtl/vga_axis_counter.sv | 58 +++++
 rtl/vga_timing_gen.sv | 180 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared raster timing constants, mode record and width helpers
// for the text-mode display path.
package vga_pkg;

  localparam int unsigned H_VIS_DEF   = 640;
  localparam int unsigned H_FRONT_DEF = 16;
  localparam int unsigned H_SYNC_DEF  = 96;
  localparam int unsigned H_BACK_DEF  = 48;
  localparam int unsigned V_VIS_DEF   = 480;
  localparam int unsigned V_FRONT_DEF = 10;
  localparam int unsigned V_SYNC_DEF  = 2;
  localparam int unsigned V_BACK_DEF  = 33;

  typedef struct packed {
    int unsigned vis;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } axis_t;

  typedef struct packed {
    axis_t h;
    axis_t v;
  } mode_t;

  localparam mode_t MODE_640X480 = '{
    h: '{H_VIS_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF},
    v: '{V_VIS_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF}
  };

  function automatic int clog2(input int unsigned x);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(x)) r = r + 1;
    return r;
  endfunction

  // Width of a field holding 0..x-1, never zero.
  function automatic int bits(input int unsigned x);
    return (clog2(x) > 0) ? clog2(x) : 1;
  endfunction

  function automatic bit is_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with registered visibility
// and sync decoded from the next count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned VIS      = H_VIS_DEF,
  parameter int unsigned FRONT    = H_FRONT_DEF,
  parameter int unsigned SYNC     = H_SYNC_DEF,
  parameter int unsigned BACK     = H_BACK_DEF,
  parameter bit          SYNC_ACT = 1'b0,
  localparam int unsigned TOTAL   = VIS + FRONT + SYNC + BACK,
  localparam int          W       = bits(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] count_d_o,
  output logic         vis_o,
  output logic         sync_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST   = W'(TOTAL - 1);
  localparam logic [W-1:0] VIS_N  = W'(VIS);
  localparam logic [W-1:0] SYNC_B = W'(VIS + FRONT);
  localparam logic [W-1:0] SYNC_E = W'(VIS + FRONT + SYNC - 1);

  logic [W-1:0] count_q, count_d;
  logic         vis_q, sync_q;

  assign wrap_o = adv_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (adv_i)
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= LAST;
      vis_q   <= 1'b0;
      sync_q  <= ~SYNC_ACT;
    end else begin
      count_q <= count_d;
      vis_q   <= count_d < VIS_N;
      sync_q  <= (count_d >= SYNC_B && count_d <= SYNC_E)
               ? SYNC_ACT : ~SYNC_ACT;
    end
  end

  assign count_o   = count_q;
  assign count_d_o = count_d;
  assign vis_o     = vis_q;
  assign sync_o    = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing: sync, visibility, strobes, VRAM fetch
// window, character-cell coordinates and blink phase.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE    = H_VIS_DEF,
  parameter int unsigned H_FRONT      = H_FRONT_DEF,
  parameter int unsigned H_SYNC       = H_SYNC_DEF,
  parameter int unsigned H_BACK       = H_BACK_DEF,
  parameter int unsigned V_VISIBLE    = V_VIS_DEF,
  parameter int unsigned V_FRONT      = V_FRONT_DEF,
  parameter int unsigned V_SYNC       = V_SYNC_DEF,
  parameter int unsigned V_BACK       = V_BACK_DEF,
  parameter bit          HSYNC_ACTIVE = 1'b0,
  parameter bit          VSYNC_ACTIVE = 1'b0,
  parameter int unsigned CELL_W       = 8,
  parameter int unsigned CELL_H       = 16,
  parameter int unsigned FETCH_LEAD   = 2,
  parameter int unsigned BLINK_FRAMES = 16,
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int HW = bits(H_TOTAL),
  localparam int VW = bits(V_TOTAL),
  localparam int CW = bits(H_VISIBLE / CELL_W),
  localparam int RW = bits(V_VISIBLE / CELL_H),
  localparam int YW = bits(CELL_H)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] hCount,
  output logic [VW-1:0] vCount,
  output logic          hSync,
  output logic          vSync,
  output logic          hVis,
  output logic          vVis,
  output logic          nVis,
  output logic          lineStart,
  output logic          frameStart,
  output logic          fetchEn,
  output logic [CW-1:0] fetchCol,
  output logic [RW-1:0] charRow,
  output logic [YW-1:0] cellY,
  output logic          blink
);

  if (H_VISIBLE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_VISIBLE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0)
  begin : g_bad_interval
    $error("timing intervals must all be non-zero");
  end
  if (!is_pow2(CELL_W) || !is_pow2(CELL_H) ||
      (H_VISIBLE % CELL_W) != 0 || (V_VISIBLE % CELL_H) != 0)
  begin : g_bad_cell
    $error("cell size must be a power of 2 dividing the visible area");
  end
  if (FETCH_LEAD > H_BACK) begin : g_bad_lead
    $error("fetch lead exceeds horizontal back porch");
  end
  if (BLINK_FRAMES == 0) begin : g_bad_blink
    $error("blink half-period must be at least one frame");
  end

  localparam int SW = bits(CELL_W);
  localparam int FW = bits(BLINK_FRAMES);
  localparam int CY_SH = clog2(CELL_H);

  localparam logic [HW-1:0] H_VIS_N   = HW'(H_VISIBLE);
  localparam logic [HW-1:0] FETCH_END = HW'(H_VISIBLE - FETCH_LEAD);
  localparam logic [HW-1:0] FETCH_BEG = HW'(H_TOTAL - FETCH_LEAD);
  localparam logic [VW-1:0] V_VIS_N   = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_PRE     = VW'(V_VISIBLE - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] CY_MASK   = VW'(CELL_H - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(V_VISIBLE / CELL_H - 1);
  localparam logic [SW-1:0] SUB_LAST  = SW'(CELL_W - 1);
  localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);

  logic [HW-1:0] h_d;
  logic [VW-1:0] v_d;
  logic          h_wrap, v_wrap;

  vga_axis_counter #(
    .VIS(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .SYNC_ACT(HSYNC_ACTIVE)
  ) u_h (
    .clk(clk), .rst(rst), .adv_i(1'b1),
    .count_o(hCount), .count_d_o(h_d),
    .vis_o(hVis), .sync_o(hSync), .wrap_o(h_wrap)
  );

  vga_axis_counter #(
    .VIS(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .SYNC_ACT(VSYNC_ACTIVE)
  ) u_v (
    .clk(clk), .rst(rst), .adv_i(h_wrap),
    .count_o(vCount), .count_d_o(v_d),
    .vis_o(vVis), .sync_o(vSync), .wrap_o(v_wrap)
  );

  logic          nvis_q, nvis_d;
  logic          ls_q, fs_q, fs_d;
  logic          fetch_q, fetch_d;
  logic [CW-1:0] col_q, col_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [RW-1:0] row_q, row_d;
  logic [YW-1:0] cy_q, cy_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          blink_q, blink_d;

  assign fs_d = h_wrap && v_wrap;

  always_comb begin
    nvis_d  = !(h_d < H_VIS_N && v_d < V_VIS_N);
    fetch_d = (h_d < FETCH_END) && (v_d < V_VIS_N);
    // Lead-in at the end of the line before a visible one.
    if (FETCH_LEAD > 0 && h_d >= FETCH_BEG &&
        (v_d < V_PRE || v_d == V_LAST))
      fetch_d = 1'b1;
    col_d = col_q;
    sub_d = sub_q;
    if (fetch_d && !fetch_q) begin
      col_d = '0;
      sub_d = '0;
    end else if (fetch_d) begin
      sub_d = sub_q + 1'b1;
      if (sub_q == SUB_LAST) begin
        sub_d = '0;
        col_d = col_q + 1'b1;
      end
    end
    row_d = (v_d < V_VIS_N) ? RW'(v_d >> CY_SH) : ROW_MAX;
    cy_d  = YW'(v_d & CY_MASK);
    frm_d   = frm_q;
    blink_d = blink_q;
    if (fs_d) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        blink_d = ~blink_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nvis_q  <= 1'b1;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fetch_q <= 1'b0;
      col_q   <= '0;
      sub_q   <= '0;
      row_q   <= '0;
      cy_q    <= '0;
      frm_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      nvis_q  <= nvis_d;
      ls_q    <= h_wrap;
      fs_q    <= fs_d;
      fetch_q <= fetch_d;
      col_q   <= col_d;
      sub_q   <= sub_d;
      row_q   <= row_d;
      cy_q    <= cy_d;
      frm_q   <= frm_d;
      blink_q <= blink_d;
    end
  end

  assign nVis       = nvis_q;
  assign lineStart  = ls_q;
  assign frameStart = fs_q;
  assign fetchEn    = fetch_q;
  assign fetchCol   = col_q;
  assign charRow    = row_q;
  assign cellY      = cy_q;
  assign blink      = blink_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 46x58 raster
// so whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int HV = 32, HF = 4, HS = 6, HB = 4, HT = 46;
  localparam int VV = 48, VF = 3, VS = 2, VB = 5, VT = 58;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] hCount, vCount;
  logic       hSync, vSync, hVis, vVis, nVis;
  logic       lineStart, frameStart, fetchEn, blink;
  logic [1:0] fetchCol, charRow;
  logic [3:0] cellY;

  int n_run  = 0;
  int n_fail = 0;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_ACTIVE(1'b0), .VSYNC_ACTIVE(1'b0),
    .CELL_W(8), .CELL_H(16), .FETCH_LEAD(2), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .hCount(hCount), .vCount(vCount),
    .hSync(hSync), .vSync(vSync),
    .hVis(hVis), .vVis(vVis), .nVis(nVis),
    .lineStart(lineStart), .frameStart(frameStart),
    .fetchEn(fetchEn), .fetchCol(fetchCol),
    .charRow(charRow), .cellY(cellY), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string p);
    check({p, ".hCount"}, 32'(hCount), HT - 1);
    check({p, ".vCount"}, 32'(vCount), VT - 1);
    check({p, ".hSync"}, 32'(hSync), 1);
    check({p, ".vSync"}, 32'(vSync), 1);
    check({p, ".hVis"}, 32'(hVis), 0);
    check({p, ".vVis"}, 32'(vVis), 0);
    check({p, ".nVis"}, 32'(nVis), 1);
    check({p, ".lineStart"}, 32'(lineStart), 0);
    check({p, ".frameStart"}, 32'(frameStart), 0);
    check({p, ".fetchEn"}, 32'(fetchEn), 0);
    check({p, ".fetchCol"}, 32'(fetchCol), 0);
    check({p, ".charRow"}, 32'(charRow), 0);
    check({p, ".cellY"}, 32'(cellY), 0);
    check({p, ".blink"}, 32'(blink), 0);
  endtask

  task automatic check_first(input string p);
    check({p, ".hCount"}, 32'(hCount), 0);
    check({p, ".vCount"}, 32'(vCount), 0);
    check({p, ".lineStart"}, 32'(lineStart), 1);
    check({p, ".frameStart"}, 32'(frameStart), 1);
    check({p, ".hVis"}, 32'(hVis), 1);
    check({p, ".vVis"}, 32'(vVis), 1);
    check({p, ".nVis"}, 32'(nVis), 0);
    check({p, ".hSync"}, 32'(hSync), 1);
    check({p, ".vSync"}, 32'(vSync), 1);
    check({p, ".fetchEn"}, 32'(fetchEn), 1);
    check({p, ".fetchCol"}, 32'(fetchCol), 0);
    check({p, ".blink"}, 32'(blink), 0);
  endtask

  task automatic wait_hv(input int h, input int v);
    bit ok = 1'b0;
    for (int i = 0; i < 2 * FRAME && !ok; i++) begin
      @(negedge clk);
      if (32'(hCount) == h && 32'(vCount) == v) ok = 1'b1;
    end
    check($sformatf("wait_%0d_%0d", h, v), 32'(ok), 1);
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frameStart && n < FRAME + 10);
  endtask

  initial begin
    int cyc, n, k;
    int hs_lo, vs_lo, f_clk, rises;
    int e_hs, e_vs, e_vse, e_rise, e_fall, e_col;
    int e_vis, e_str, e_row, e_blk;
    int hh, vv, exp_row;
    bit prev_f, prev_vs, seen, hs_win, vs_win;

    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    @(negedge clk);
    check_first("first");

    {hs_lo, vs_lo, f_clk, rises} = '0;
    {e_hs, e_vs, e_vse, e_rise, e_fall, e_col} = '0;
    {e_vis, e_str, e_row, e_blk} = '0;
    prev_f  = fetchEn;
    prev_vs = vSync;
    seen    = 1'b0;
    k       = 0;
    cyc     = 0;
    do begin
      hh = 32'(hCount);
      vv = 32'(vCount);
      hs_win = (hh >= 36 && hh <= 41);
      vs_win = (vv >= 51 && vv <= 52);
      if (!hSync) hs_lo++;
      if (!vSync) vs_lo++;
      if (!hSync != hs_win) e_hs++;
      if (!vSync != vs_win) e_vs++;
      if (vSync != prev_vs && hh != 0) e_vse++;
      if (fetchEn) f_clk++;
      if (fetchEn && !prev_f) begin
        rises++;
        seen = 1'b1;
        k = 0;
        if (hh != 44) e_rise++;
      end
      if (!fetchEn && prev_f && hh != 30) e_fall++;
      if (seen) begin
        if (fetchEn) begin
          if (32'(fetchCol) != k / 8) e_col++;
          k++;
        end else if (fetchCol != 2'd3) begin
          e_col++;
        end
      end
      if (hVis != (hh < HV) || vVis != (vv < VV) ||
          nVis != !(hh < HV && vv < VV)) e_vis++;
      if (lineStart != (hh == 0) ||
          frameStart != (hh == 0 && vv == 0)) e_str++;
      exp_row = (vv < VV) ? vv / 16 : 2;
      if (32'(charRow) != exp_row || 32'(cellY) != vv % 16) e_row++;
      if (blink) e_blk++;
      if (vv == 37 && hh == 5) begin
        check("row_v37", 32'(charRow), 2);
        check("celly_v37", 32'(cellY), 5);
      end
      if (vv == 50 && hh == 5) begin
        check("row_v50_sat", 32'(charRow), 2);
        check("celly_v50", 32'(cellY), 2);
      end
      prev_f  = fetchEn;
      prev_vs = vSync;
      @(negedge clk);
      cyc++;
    end while (!frameStart && cyc < FRAME + 10);

    check("frame_len", cyc, FRAME);
    check("hsync_clocks", hs_lo, HS * VT);
    check("vsync_clocks", vs_lo, VS * HT);
    check("hsync_window", e_hs, 0);
    check("vsync_window", e_vs, 0);
    check("vsync_edge_h0", e_vse, 0);
    check("fetch_clocks", f_clk, VV * HV);
    check("fetch_rises", rises, VV);
    check("fetch_rise_h", e_rise, 0);
    check("fetch_fall_h", e_fall, 0);
    check("fetch_col", e_col, 0);
    check("vis_decode", e_vis, 0);
    check("strobes", e_str, 0);
    check("row_celly", e_row, 0);
    check("blink_frame1", e_blk, 0);
    check("blink_frame2", 32'(blink), 1);

    for (int f = 3; f <= 6; f++) begin
      wait_frame(n);
      check($sformatf("frame%0d_len", f), n, FRAME);
      check($sformatf("blink_frame%0d", f), 32'(blink), (f / 2) % 2);
    end

    wait_hv(20, 30);
    rst = 1'b1;
    #1;
    check_reset("mid_rst");
    repeat (3) @(negedge clk);
    check_reset("hold_rst");
    rst = 1'b0;
    @(negedge clk);
    check_first("restart");
    @(negedge clk);
    check("restart_h1", 32'(hCount), 1);
    check("restart_fs", 32'(frameStart), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
